fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters, one per line:
- AW, 16, instruction address width.
- DW, 32, instruction width.
- TMO, 15, maximum cycles to wait for memory acknowledge.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on the posedge.
- rst_f, in, 1, reset; synchronous and active-high.
- fetch_req, in, 1, single-cycle pulse from the control FSM (fetch state) requesting the next instruction.
- pc_ld, in, 1, load the PC with a branch target.
- br_rel, in, 1, with pc_ld: 1 = relative target, 0 = absolute target.
- br_addr, in, AW, absolute target, or signed offset when br_rel = 1.
- imem_req, out, 1, memory read request.
- imem_addr, out, AW, memory read address.
- imem_ack, in, 1, memory data valid.
- imem_rdata, in, DW, memory read data.
- instr, out, DW, instruction register (IR).
- opcode, out, 4, IR[31:28], consumed by control.
- mm, out, 4, IR[27:24], addressing mode, consumed by control.
- pc, out, AW, current PC.
- instr_valid, out, 1, one-cycle pulse when the IR is updated.
- busy, out, 1, fetch in progress.
- fetch_err, out, 1, sticky flag: acknowledge timeout occurred.

Function
REQ-003 FSM states: IDLE, WAIT, DONE.
- IDLE -> WAIT on fetch_req.
- WAIT -> DONE on imem_ack.
- WAIT -> IDLE on timeout.
- DONE -> IDLE unconditionally.
REQ-004 imem_req and busy are asserted exactly while in WAIT.
- imem_addr equals the PC latched at entry to WAIT.
- imem_addr is held stable until WAIT is exited.
REQ-005 When imem_ack is seen in WAIT:
- IR loads imem_rdata on that edge.
- instr_valid is high for the single DONE cycle.
- Latency from the fetch_req edge to instr_valid is 1 + N cycles, where N is the number of WAIT cycles (N >= 1).
REQ-006 On fetch completion the PC becomes the pending target if one exists, otherwise PC+1.
- The PC is word-addressed.
- 16'hFFFF wraps to 16'h0000.
REQ-007 pc_ld in IDLE or DONE updates the PC on that edge.
- br_rel = 0: PC := br_addr.
- br_rel = 1: PC := PC + sign-extended br_addr, modulo 2^AW.
REQ-008 pc_ld together with fetch_req in IDLE: the fetch uses the new target, not the old PC.
REQ-009 pc_ld in WAIT does not change the PC or imem_addr.
- The target is computed against the fetching PC and stored as pending.
- The pending target is applied per REQ-006.
- A later pc_ld in the same WAIT overwrites the pending target.
REQ-010 fetch_req outside IDLE is ignored and is not queued.
REQ-011 A timeout counter clears on entry to WAIT and counts each WAIT cycle without imem_ack.
- When the count reaches TMO: go to IDLE, set fetch_err, leave IR and PC unchanged, discard any pending target.
- fetch_err is cleared only by reset.
REQ-012 imem_ack outside WAIT is ignored.
REQ-013 opcode and mm are combinational slices of the IR.

Reset
REQ-014 While rst_f = 1 at a posedge:
- state := IDLE.
- PC := 0, IR := 0 (therefore opcode = 0, NOOP; mm = 0).
- instr_valid, imem_req, busy, fetch_err := 0.
- The pending target and timeout counter are cleared.
REQ-015 Reset during WAIT aborts the fetch immediately.
- imem_req drops on the next cycle.
- A late imem_ack is ignored.
REQ-016 No asynchronous reset paths exist.

Structure
REQ-017 A shared package holds:
- FSM state encoding.
- Opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15).
- am_imm=8.
- IR field bit positions.
REQ-018 One sub-module, pc_reg, holds the PC register, increment, relative/absolute target adder and pending-target logic; the FSM and IR stay in fetch_unit.

Verification
REQ-019 Reset, then fetch_req with imem_ack on the 2nd WAIT cycle and rdata = 32'h8100_0003 -> instr_valid 3 cycles after fetch_req, opcode = 8, mm = 1, pc = 1.
REQ-020 PC = 16'hFFFF, fetch with ack -> pc = 16'h0000.
REQ-021 PC = 10, pc_ld with br_rel = 1 and br_addr = 16'hFFFC, same cycle as fetch_req -> imem_addr = 6; after ack, pc = 7.
REQ-022 pc_ld absolute 16'h0040 during WAIT, then ack -> imem_addr unchanged during WAIT; afterwards pc = 16'h0040 (not PC+1).
REQ-023 No ack for TMO cycles -> imem_req drops, fetch_err = 1, IR and PC unchanged; a late ack produces no instr_valid.
REQ-024 rst_f pulsed mid-WAIT -> next cycle imem_req = 0, pc = 0, opcode = 0; the following ack is ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared FSM encoding, opcodes and IR field positions for the fetch path
package fetch_unit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] SWP    = 4'd3;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] BNR    = 4'd7;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;
  localparam logic [3:0] AM_IMM = 4'd8;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;
  localparam int MM_MSB = 27;
  localparam int MM_LSB = 24;
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter with increment, branch target adder and a pending target deferred to fetch completion
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          pc_ld,
  input  logic          br_rel,
  input  logic [AW-1:0] br_addr,
  input  logic          in_wait,
  input  logic          done,
  input  logic          abort,
  output logic [AW-1:0] pc
);
  logic [AW-1:0] tgt, pend;
  logic pend_v;
  assign tgt = br_rel ? pc + br_addr : br_addr;
  // while fetching, the PC must stay put for imem_addr, so branches are parked
  always_ff @(posedge clk)
    if (rst_f) begin
      pc <= '0;
      pend <= '0;
      pend_v <= 1'b0;
    end else if (in_wait) begin
      if (done) begin
        pc <= pc_ld ? tgt : pend_v ? pend : pc + AW'(1);
        pend_v <= 1'b0;
      end else if (abort) begin
        pend_v <= 1'b0;
      end else if (pc_ld) begin
        pend <= tgt;
        pend_v <= 1'b1;
      end
    end else if (pc_ld) begin
      pc <= tgt;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with IR, ack timeout and sticky error flag
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_req,
  input  logic          pc_ld,
  input  logic          br_rel,
  input  logic [AW-1:0] br_addr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] instr,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [AW-1:0] pc,
  output logic          instr_valid,
  output logic          busy,
  output logic          fetch_err
);
  localparam int CW = $clog2(TMO + 1);
  state_t st, nx;
  logic [CW-1:0] cnt;
  logic ack_w, tmo;
  assign ack_w = st == S_WAIT && imem_ack;
  assign tmo = st == S_WAIT && !imem_ack && cnt == CW'(TMO - 1);
  always_ff @(posedge clk)
    st <= rst_f ? S_IDLE : nx;
  always_comb begin
    nx = st;
    if (st == S_IDLE && fetch_req) nx = S_WAIT;
    else if (ack_w) nx = S_DONE;
    else if (tmo || st == S_DONE) nx = S_IDLE;
  end
  always_comb begin
    imem_req = st == S_WAIT;
    busy = st == S_WAIT;
    instr_valid = st == S_DONE;
  end
  // counter is zero whenever WAIT is entered, so it needs no explicit entry clear
  always_ff @(posedge clk)
    if (rst_f) begin
      cnt <= '0;
      instr <= '0;
      fetch_err <= 1'b0;
    end else begin
      cnt <= (st == S_WAIT && !imem_ack) ? cnt + CW'(1) : '0;
      if (ack_w) instr <= imem_rdata;
      if (tmo) fetch_err <= 1'b1;
    end
  assign opcode = instr[OP_MSB:OP_LSB];
  assign mm = instr[MM_MSB:MM_LSB];
  assign imem_addr = pc;
  pc_reg #(.AW(AW)) u_pc (
    .clk(clk),
    .rst_f(rst_f),
    .pc_ld(pc_ld),
    .br_rel(br_rel),
    .br_addr(br_addr),
    .in_wait(st == S_WAIT),
    .done(ack_w),
    .abort(tmo),
    .pc(pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios with an expected-instruction scoreboard
module tb_fetch_unit;
  localparam int TMO = 15;
  typedef struct {
    logic [31:0] ir;
    logic [15:0] pc;
  } exp_t;
  logic clk = 0, rst_f = 1, fetch_req = 0, pc_ld = 0, br_rel = 0, imem_ack = 0;
  logic [15:0] br_addr = '0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, instr_valid, busy, fetch_err;
  logic [15:0] imem_addr, pc;
  logic [31:0] instr;
  logic [3:0] opcode, mm;
  exp_t q[$];
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  fetch_unit #(.AW(16), .DW(32), .TMO(TMO)) dut (
    .clk(clk), .rst_f(rst_f), .fetch_req(fetch_req), .pc_ld(pc_ld), .br_rel(br_rel),
    .br_addr(br_addr), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode), .mm(mm), .pc(pc),
    .instr_valid(instr_valid), .busy(busy), .fetch_err(fetch_err)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic load_pc(input logic [15:0] a);
    pc_ld = 1; br_rel = 0; br_addr = a;
    step();
    pc_ld = 0;
    chk("pc_load", pc, a);
  endtask
  task automatic fetch_go(input logic [15:0] addr);
    fetch_req = 1;
    step();
    fetch_req = 0; pc_ld = 0;
    chk("req_high", imem_req, 1);
    chk("busy_high", busy, 1);
    chk("imem_addr", imem_addr, addr);
  endtask
  task automatic do_ack(input logic [31:0] data);
    exp_t e;
    imem_ack = 1; imem_rdata = data;
    step();
    imem_ack = 0;
    chk("valid_pulse", instr_valid, 1);
    chk("sb_nonempty", q.size(), q.size() == 0 ? 1 : q.size());
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("instr", instr, e.ir);
      chk("opcode", opcode, e.ir[31:28]);
      chk("mm", mm, e.ir[27:24]);
      chk("pc_after", pc, e.pc);
    end
    step();
    chk("valid_drop", instr_valid, 0);
  endtask
  initial begin
    int n;
    step(); step();
    rst_f = 0;
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    // basic fetch, ack on 2nd WAIT cycle -> valid three edges after fetch_req
    q.push_back('{32'h8100_0003, 16'd1});
    fetch_go(16'd0);
    step();
    chk("wait2_req", imem_req, 1);
    do_ack(32'h8100_0003);
    // PC wrap
    load_pc(16'hFFFF);
    q.push_back('{32'h1000_0000, 16'h0000});
    fetch_go(16'hFFFF);
    do_ack(32'h1000_0000);
    // relative branch in same cycle as fetch_req
    load_pc(16'd10);
    pc_ld = 1; br_rel = 1; br_addr = 16'hFFFC;
    q.push_back('{32'h5F00_0001, 16'd7});
    fetch_go(16'd6);
    br_rel = 0;
    do_ack(32'h5F00_0001);
    // branches during WAIT are deferred; the later one wins; fetch_req in WAIT ignored
    q.push_back('{32'h4000_0010, 16'h0040});
    fetch_go(16'd7);
    pc_ld = 1; br_addr = 16'h0020;
    step();
    chk("wait_addr_hold", imem_addr, 7);
    chk("wait_pc_hold", pc, 7);
    br_addr = 16'h0040; fetch_req = 1;
    step();
    pc_ld = 0; fetch_req = 0;
    chk("wait_addr_hold2", imem_addr, 7);
    do_ack(32'h4000_0010);
    chk("no_queued_fetch", busy, 0);
    step();
    chk("no_queued_fetch2", imem_req, 0);
    // timeout: pending target discarded, IR and PC kept, late ack ignored
    fetch_go(16'h0040);
    pc_ld = 1; br_addr = 16'h0099;
    n = 1;
    while (imem_req === 1'b1 && n < 40) begin
      step();
      pc_ld = 0;
      if (imem_req === 1'b1) n++;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_req_low", imem_req, 0);
    chk("tmo_err", fetch_err, 1);
    chk("tmo_pc", pc, 16'h0040);
    chk("tmo_instr", instr, 32'h4000_0010);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 0;
    chk("late_ack_valid", instr_valid, 0);
    chk("late_ack_instr", instr, 32'h4000_0010);
    chk("err_sticky", fetch_err, 1);
    // reset mid-WAIT aborts the fetch
    fetch_go(16'h0040);
    step();
    rst_f = 1;
    step();
    rst_f = 0;
    chk("rstw_req", imem_req, 0);
    chk("rstw_pc", pc, 0);
    chk("rstw_opcode", opcode, 0);
    chk("rstw_err", fetch_err, 0);
    imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
    step();
    imem_ack = 0;
    chk("rstw_ack_valid", instr_valid, 0);
    chk("rstw_ack_instr", instr, 0);
    step();
    chk("rstw_idle", busy, 0);
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
